// File: rtl/flappy_pkg.sv
// Shared types, geometry/physics constants and helpers for the flappy game core.
package flappy_pkg;

  localparam int unsigned Y_W      = 10;
  localparam int unsigned P_W      = 9;
  localparam int unsigned S_W      = 10;
  localparam int unsigned V_W      = 6;
  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned RND_W    = 7;

  localparam int SCREEN_H  = 480;
  localparam int X_WRAP    = 480;
  localparam int BIRD_X    = 100;
  localparam int BIRD_W    = 16;
  localparam int BIRD_H    = 16;
  localparam int Y_START   = 240;
  localparam int PILLAR_W  = 40;
  localparam int GAP_H     = 120;
  localparam int GAP_MIN   = 40;
  localparam int SCROLL    = 2;
  localparam int GRAVITY   = 1;
  localparam int FLAP_VEL  = -8;
  localparam int MAX_FALL  = 8;
  localparam int SCORE_MAX = 999;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [P_W-1:0]    P1_RST    = 9'd479;
  localparam logic [P_W-1:0]    P2_RST    = 9'd239;
  localparam logic [P_W-1:0]    GAP1_RST  = 9'd180;
  localparam logic [P_W-1:0]    GAP2_RST  = 9'd120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic [P_W-1:0] gap;
    logic           scored;
  } pstep_t;

  // Scroll one pillar; wrap reloads a fresh gap, scoring only on a real left crossing.
  function automatic pstep_t pillar_step(input logic [P_W-1:0] p, input logic [P_W-1:0] gap,
                                         input logic [RND_W-1:0] rnd);
    pstep_t r;
    r.scored = 1'b0;
    if (int'(p) < SCROLL) begin
      r.p   = P_W'(X_WRAP - 1);
      r.gap = P_W'(GAP_MIN + int'(rnd));
    end else begin
      r.p      = p - P_W'(SCROLL);
      r.gap    = gap;
      r.scored = (int'(p) + PILLAR_W >= BIRD_X) && (int'(p) - SCROLL + PILLAR_W < BIRD_X);
    end
    return r;
  endfunction

  function automatic logic pillar_hit(input logic [P_W-1:0] p, input logic [P_W-1:0] gap,
                                      input logic [Y_W-1:0] y);
    return (int'(p) < BIRD_X + BIRD_W) && (int'(p) + PILLAR_W > BIRD_X) &&
           ((int'(y) < int'(gap)) || (int'(y) + BIRD_H > int'(gap) + GAP_H));
  endfunction

endpackage

// File: rtl/flappy_game_core_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free running, seeded on reset.
module lfsr8
  import flappy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [RND_W-1:0]  rnd
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  // Only the low bits feed gap selection.
  assign rnd = lfsr_q[RND_W-1:0];

endmodule

// File: rtl/flappy_game_core.sv
// Flappy Bird game logic: one frame per clk, bird physics, two scrolling pillars, scoring.
module flappy_game_core
  import flappy_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flap,
  output logic [Y_W-1:0] y,
  output logic [P_W-1:0] p1,
  output logic [P_W-1:0] p2,
  output logic [P_W-1:0] gap1,
  output logic [P_W-1:0] gap2,
  output logic [S_W-1:0] score,
  output logic [S_W-1:0] high_score,
  output logic           lost,
  output logic [1:0]     state
);

  state_e                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d, y_n;
  logic signed [V_W-1:0] vel_q, vel_d;
  logic [P_W-1:0]        p1_q, p1_d, p2_q, p2_d;
  logic [P_W-1:0]        gap1_q, gap1_d, gap2_q, gap2_d;
  logic [S_W-1:0]        score_q, score_d, high_q, high_d;
  logic                  lost_q, lost_d, flap_q;
  logic [RND_W-1:0]      rnd;
  logic                  fe, ground, hit, play_upd;
  pstep_t                s1, s2;
  int                    vel_n, t, score_n;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .rnd  (rnd)
  );

  assign fe = flap & ~flap_q;
  assign s1 = pillar_step(p1_q, gap1_q, rnd);
  assign s2 = pillar_step(p2_q, gap2_q, rnd);

  // Candidate PLAY update from current registers.
  always_comb begin
    vel_n = fe ? FLAP_VEL : int'(vel_q) + GRAVITY;
    if (vel_n > MAX_FALL) vel_n = MAX_FALL;
    t      = int'(y_q) + vel_n;
    y_n    = Y_W'(t);
    ground = 1'b0;
    if (t < 0) begin
      y_n = '0;
    end else if (t >= SCREEN_H - BIRD_H) begin
      y_n    = Y_W'(SCREEN_H - BIRD_H);
      ground = 1'b1;
    end
    hit = ground | pillar_hit(p1_q, gap1_q, y_q) | pillar_hit(p2_q, gap2_q, y_q);
    // A start from IDLE counts from a cleared score.
    score_n = ((state_q == ST_IDLE) ? 0 : int'(score_q)) + int'(s1.scored) + int'(s2.scored);
    if (score_n > SCORE_MAX) score_n = SCORE_MAX;
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vel_d    = vel_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    gap1_d   = gap1_q;
    gap2_d   = gap2_q;
    score_d  = score_q;
    high_d   = high_q;
    lost_d   = lost_q;
    play_upd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fe) begin
          play_upd = 1'b1;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: play_upd = 1'b1;
      ST_DEAD: begin
        if (fe) begin
          state_d = ST_IDLE;
          y_d     = Y_W'(Y_START);
          vel_d   = '0;
          p1_d    = P1_RST;
          p2_d    = P2_RST;
          gap1_d  = GAP1_RST;
          gap2_d  = GAP2_RST;
          lost_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (play_upd) begin
      vel_d   = V_W'(vel_n);
      y_d     = y_n;
      p1_d    = s1.p;
      gap1_d  = s1.gap;
      p2_d    = s2.p;
      gap2_d  = s2.gap;
      score_d = S_W'(score_n);
      if (hit) begin
        state_d = ST_DEAD;
        lost_d  = 1'b1;
        high_d  = (int'(high_q) > score_n) ? high_q : S_W'(score_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= Y_W'(Y_START);
      vel_q   <= '0;
      p1_q    <= P1_RST;
      p2_q    <= P2_RST;
      gap1_q  <= GAP1_RST;
      gap2_q  <= GAP2_RST;
      score_q <= '0;
      high_q  <= '0;
      lost_q  <= 1'b0;
      flap_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      gap1_q  <= gap1_d;
      gap2_q  <= gap2_d;
      score_q <= score_d;
      high_q  <= high_d;
      lost_q  <= lost_d;
      flap_q  <= flap;
    end
  end

  assign y          = y_q;
  assign p1         = p1_q;
  assign p2         = p2_q;
  assign gap1       = gap1_q;
  assign gap2       = gap2_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign lost       = lost_q;
  assign state      = state_q;

endmodule

// File: tb/tb_flappy_game_core.sv
// Directed bench for flappy_game_core with hand-derived trajectories.
module tb_flappy_game_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       flap;
  logic [9:0] y;
  logic [8:0] p1, p2, gap1, gap2;
  logic [9:0] score, high_score;
  logic       lost;
  logic [1:0] state;

  int n_total = 0;
  int n_bad   = 0;

  flappy_game_core dut (
    .clk        (clk),
    .rst        (rst),
    .flap       (flap),
    .y          (y),
    .p1         (p1),
    .p2         (p2),
    .gap1       (gap1),
    .gap2       (gap2),
    .score      (score),
    .high_score (high_score),
    .lost       (lost),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge and outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic f);
    flap = f;
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_y"}, int'(y), 240);
    check({tag, "_p1"}, int'(p1), 479);
    check({tag, "_p2"}, int'(p2), 239);
    check({tag, "_gap1"}, int'(gap1), 180);
    check({tag, "_gap2"}, int'(gap2), 120);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_high"}, int'(high_score), 0);
    check({tag, "_lost"}, int'(lost), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dn;
    rst  = 1'b1;
    flap = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst");
    for (int i = 0; i < 10; i++) begin
      frame(1'b0);
      check("idle_y", int'(y), 240);
      check("idle_p1", int'(p1), 479);
      check("idle_state", int'(state), 0);
    end

    // Flap held through reset must not start a game.
    rst  = 1'b1;
    flap = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("held_flap_state", int'(state), 0);
    frame(1'b0);
    frame(1'b0);
    check("released_state", int'(state), 0);

    // Start, then free fall to the ground.
    frame(1'b1);
    check("start_state", int'(state), 1);
    check("start_y", int'(y), 232);
    check("start_p1", int'(p1), 477);
    check("start_p2", int'(p2), 237);
    frame(1'b0);
    check("f2_y", int'(y), 225);
    for (int n = 3; n <= 44; n++) begin
      frame(1'b0);
      if (n == 9)  check("f9_y_apex", int'(y), 204);
      if (n == 17) check("f17_y", int'(y), 240);
    end
    check("f44_y", int'(y), 456);
    check("f44_state", int'(state), 1);
    frame(1'b0);
    check("ground_state", int'(state), 2);
    check("ground_y", int'(y), 464);
    check("ground_lost", int'(lost), 1);
    check("ground_high", int'(high_score), 0);
    check("ground_p1", int'(p1), 389);
    check("ground_p2", int'(p2), 149);
    for (int i = 0; i < 20; i++) frame(1'b0);
    check("frozen_y", int'(y), 464);
    check("frozen_p1", int'(p1), 389);
    check("frozen_p2", int'(p2), 149);
    check("frozen_state", int'(state), 2);

    frame(1'b1);
    check("dead2idle_state", int'(state), 0);
    check("dead2idle_y", int'(y), 240);
    check("dead2idle_p2", int'(p2), 239);
    check("dead2idle_lost", int'(lost), 0);
    frame(1'b0);

    // Game A: flap every 16 frames, bird climbs 8 px per period inside gap2.
    for (int n = 1; n <= 120; n++) begin
      frame(((n - 1) % 16) == 0);
      if (n == 89) begin
        check("a89_p2", int'(p2), 61);
        check("a89_score", int'(score), 0);
        check("a89_y", int'(y), 164);
      end
      if (n == 90) begin
        check("a90_p2", int'(p2), 59);
        check("a90_score", int'(score), 1);
        check("a90_y", int'(y), 165);
        check("a90_state", int'(state), 1);
      end
      if (n == 119) check("a119_p2", int'(p2), 1);
    end
    check("a120_p2_wrap", int'(p2), 479);
    check("a120_gap2_range", int'((gap2 >= 9'd40) && (gap2 <= 9'd167)), 1);
    check("a120_state", int'(state), 1);
    dn = 0;
    for (int n = 121; n <= 220 && state != 2'd2; n++) begin
      frame(1'b0);
      dn = n;
    end
    check("a_die_frame", dn, 164);
    check("a_dead_state", int'(state), 2);
    check("a_dead_y", int'(y), 464);
    check("a_dead_score", int'(score), 1);
    check("a_dead_high", int'(high_score), 1);
    check("a_dead_p1", int'(p1), 151);

    frame(1'b1);
    check("a_idle_state", int'(state), 0);
    check("a_idle_score_held", int'(score), 1);
    check("a_idle_high", int'(high_score), 1);
    check("a_idle_gap2", int'(gap2), 120);
    frame(1'b0);

    // Game B: stop flapping while p2 overlaps the bird, sink below gap2.
    for (int n = 1; n <= 67; n++) frame((n <= 64) && (((n - 1) % 16) == 0));
    check("b67_state", int'(state), 1);
    check("b67_y", int'(y), 232);
    check("b67_score", int'(score), 0);
    frame(1'b0);
    check("b68_state", int'(state), 2);
    check("b68_y", int'(y), 240);
    check("b68_p2", int'(p2), 103);
    check("b68_lost", int'(lost), 1);
    check("b68_high_kept", int'(high_score), 1);
    frame(1'b1);
    check("b_idle_state", int'(state), 0);
    check("b_idle_y", int'(y), 240);
    check("b_idle_p1", int'(p1), 479);
    check("b_idle_high", int'(high_score), 1);
    frame(1'b0);

    // Reset in the middle of play.
    frame(1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0);
    check("c_state_play", int'(state), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
